// File: rtl/ccff_bitstream_loader_pkg.sv
// ccff_bitstream_loader_pkg: shared state type and width helpers for the configuration-chain loader
package ccff_bitstream_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_SHIFT,
        ST_HOLD
    } ccff_ld_state_e;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: W-bit parallel-in/serial-out, MSB first, reloadable on its last bit for gapless output
module ccff_word_serializer
    import ccff_bitstream_loader_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         prog_clk,
    input  logic         prog_rst_n,
    input  logic         i_en,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_word,
    output logic         o_ready,
    output logic         o_bit,
    output logic         o_bit_v
);

    localparam int IW = cnt_w(W - 1);

    logic [W-1:0]  r_sr;
    logic [IW-1:0] r_idx;
    logic          r_v;
    logic          w_take;

    assign o_ready = i_en & (!r_v | (r_idx == IW'(W - 1)));
    assign w_take  = o_ready & i_valid;
    assign o_bit   = r_sr[W-1];
    assign o_bit_v = r_v;

    // Load a new word, otherwise shift one bit out per cycle while holding unsent bits
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_sr  <= '0;
            r_idx <= '0;
            r_v   <= 1'b0;
        end else if (i_flush) begin
            r_sr  <= '0;
            r_idx <= '0;
            r_v   <= 1'b0;
        end else if (w_take) begin
            r_sr  <= i_word;
            r_idx <= '0;
            r_v   <= 1'b1;
        end else if (r_v) begin
            r_sr  <= r_sr << 1;
            r_idx <= r_idx + 1'b1;
            r_v   <= (r_idx != IW'(W - 1));
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: feeds bitstream words serially into the config chain head with I/O isolation control
module ccff_bitstream_loader
    import ccff_bitstream_loader_pkg::*;
#(
    parameter int W          = 8,
    parameter int CHAIN_LEN  = 1024,
    parameter int ISOL_SETUP = 4,
    parameter int ISOL_HOLD  = 4
) (
    input  logic                           prog_clk,
    input  logic                           prog_rst_n,
    input  logic                           start,
    input  logic [W-1:0]                   cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic [$clog2(CHAIN_LEN+1)-1:0] tail_ones,
    output logic                           IO_ISOL_N,
    output logic                           busy,
    output logic                           done
);

    localparam int NW  = ceil_div(CHAIN_LEN, W);
    localparam int BW  = $clog2(CHAIN_LEN + 1);
    localparam int WCW = cnt_w(NW);
    localparam int CW  = cnt_w((ISOL_SETUP > ISOL_HOLD) ? ISOL_SETUP : ISOL_HOLD);

    ccff_ld_state_e r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [BW-1:0]  r_bit_cnt;
    logic [BW-1:0]  r_tail;
    logic [WCW-1:0] r_words;
    logic           r_isol_n;
    logic           r_done;
    logic           w_start;
    logic           w_setup_done;
    logic           w_hold_done;
    logic           w_shift_last;
    logic           w_word_en;
    logic           w_take;

    assign w_start      = start & (r_state == ST_IDLE);
    assign w_setup_done = (ISOL_SETUP == 0) || (r_cnt == CW'(ISOL_SETUP - 1));
    assign w_hold_done  = (r_cnt == CW'(ISOL_HOLD));
    assign w_shift_last = (r_state == ST_SHIFT) & ccff_shift_en & (r_bit_cnt == BW'(CHAIN_LEN - 1));
    assign w_word_en    = (r_state == ST_SHIFT) & (r_words < WCW'(NW));
    assign w_take       = cfg_ready & cfg_valid;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign IO_ISOL_N    = r_isol_n;
    assign tail_ones    = r_tail;

    ccff_word_serializer #(.W(W)) u_ser (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .i_en       (w_word_en),
        .i_flush    (w_shift_last),
        .i_valid    (cfg_valid),
        .i_word     (cfg_data),
        .o_ready    (cfg_ready),
        .o_bit      (ccff_head),
        .o_bit_v    (ccff_shift_en)
    );

    // State register
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) r_state <= ST_IDLE;
        else             r_state <= w_next;
    end

    // Next-state: isolate, shift the whole chain, hold isolation, then release
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = start ? ST_ISOLATE : ST_IDLE;
            ST_ISOLATE: w_next = w_setup_done ? ST_SHIFT : ST_ISOLATE;
            ST_SHIFT:   w_next = w_shift_last ? ST_HOLD : ST_SHIFT;
            ST_HOLD:    w_next = w_hold_done ? ST_IDLE : ST_HOLD;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Phase timer, bit/word counters, tail ones monitor and isolation/done flags
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_tail    <= '0;
            r_words   <= '0;
            r_isol_n  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 :
                     (r_state == ST_ISOLATE || r_state == ST_HOLD) ? r_cnt + 1'b1 : r_cnt;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_tail    <= '0;
                r_words   <= '0;
                r_isol_n  <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                if ((r_state == ST_SHIFT) && ccff_shift_en && (r_bit_cnt != BW'(CHAIN_LEN))) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_tail    <= r_tail + BW'(ccff_tail);
                end
                if (w_take) r_words <= r_words + 1'b1;
                if ((r_state == ST_HOLD) && w_hold_done) begin
                    r_isol_n <= 1'b1;
                    r_done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: directed loads against a chain model, bit-level scoreboard on ccff_head
module tb_ccff_bitstream_loader;

    localparam int W  = 8;
    localparam int CL = 20;
    localparam int BW = $clog2(CL + 1);

    logic          prog_clk   = 1'b0;
    logic          prog_rst_n = 1'b1;
    logic          start      = 1'b0;
    logic          cfg_valid  = 1'b0;
    logic [W-1:0]  cfg_data   = '0;
    logic          cfg_ready, ccff_head, ccff_shift_en, ccff_tail, IO_ISOL_N, busy, done;
    logic [BW-1:0] tail_ones;
    logic [CL-1:0] chain = 20'h0007F;
    logic [W-1:0]  words [3] = '{8'hA5, 8'h3C, 8'hFF};
    logic          q[$];
    int            n_chk = 0, n_pass = 0;
    int            n_shift = 0, first_c = -1, last_c = -1, cyc = 0, lat;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.W(W), .CHAIN_LEN(CL), .ISOL_SETUP(4), .ISOL_HOLD(4)) dut (
        .prog_clk      (prog_clk),
        .prog_rst_n    (prog_rst_n),
        .start         (start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .tail_ones     (tail_ones),
        .IO_ISOL_N     (IO_ISOL_N),
        .busy          (busy),
        .done          (done)
    );

    assign ccff_tail = chain[CL-1];

    // Configuration chain model: advances only on enabled edges
    always @(posedge prog_clk)
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Scoreboard consumer: every enabled cycle must carry the next expected bit
    always @(negedge prog_clk) begin
        logic e;
        cyc++;
        if (ccff_shift_en === 1'b1) begin
            n_shift++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            e = (q.size() > 0) ? q.pop_front() : 1'bx;
            chk($sformatf("head_bit%0d", n_shift), 32'(ccff_head), 32'(e));
        end
    end

    task automatic do_load(input int stall, input bit poke, input int rst_bit, output int lat_o);
        int wi, stall_left, extra_rdy, pushed, exp_tail;
        exp_tail = $countones(chain);
        q.delete();
        n_shift = 0; first_c = -1; last_c = -1;
        wi = 0; stall_left = stall; extra_rdy = 0; pushed = 0; lat_o = -1;
        @(negedge prog_clk); #1 start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge prog_clk); #1;
            start = poke && (k == 2 || k == 10 || k == 27 || k == 29);
            if (done) begin
                lat_o = k;
                break;
            end
            if (rst_bit > 0 && n_shift == rst_bit) begin
                #1 prog_rst_n = 1'b0;
                #1;
                chk("rst_outs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, IO_ISOL_N}), 0);
                chk("rst_tail", 32'(tail_ones), 0);
                cfg_valid = 1'b0;
                lat_o = -2;
                @(negedge prog_clk); #1 prog_rst_n = 1'b1;
                break;
            end
            if (k == 1) chk("busy_isol", 32'({busy, IO_ISOL_N}), 32'(2'b10));
            if (wi < 3) begin
                cfg_data  = words[wi];
                cfg_valid = !(wi == 1 && stall_left > 0);
                if (wi == 1 && stall_left > 0 && cfg_ready) stall_left--;
            end else begin
                cfg_data  = '0;
                cfg_valid = 1'b1;
                if (cfg_ready) extra_rdy++;
            end
            if (cfg_valid && cfg_ready && wi < 3) begin
                for (int b = W - 1; b >= 0; b--)
                    if (pushed < CL) begin
                        q.push_back(words[wi][b]);
                        pushed++;
                    end
                wi++;
            end
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        if (rst_bit == 0) begin
            chk("latency", lat_o, 30 + stall);
            chk("shift_cnt", n_shift, CL);
            chk("shift_span", last_c - first_c + 1, CL + stall);
            chk("sb_left", q.size(), 0);
            chk("words_acc", wi, 3);
            chk("extra_ready", extra_rdy, 0);
            chk("tail_ones", 32'(tail_ones), exp_tail);
            chk("isol_rel", 32'({IO_ISOL_N, busy}), 32'(2'b10));
        end
    endtask

    initial begin
        #1 prog_rst_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        #1;
        chk("reset_outs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, IO_ISOL_N}), 0);
        chk("reset_tail", 32'(tail_ones), 0);
        prog_rst_n = 1'b1;
        repeat (10) begin
            @(negedge prog_clk); #1;
            chk("idle", 32'({IO_ISOL_N, done, cfg_ready, ccff_shift_en, busy}), 0);
        end
        do_load(0, 1'b0, 0, lat);
        do_load(0, 1'b0, 0, lat);
        chk("tail_second", 32'(tail_ones), 12);
        do_load(5, 1'b0, 0, lat);
        do_load(0, 1'b0, 9, lat);
        do_load(0, 1'b0, 0, lat);
        do_load(0, 1'b1, 0, lat);
        repeat (10) begin
            @(negedge prog_clk); #1;
            chk("post_idle", 32'({busy, done, IO_ISOL_N}), 32'(3'b011));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
